// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operation/operand bus and result/status signals of the execute unit
interface alu_muldiv_if #(parameter int WIDTH = 32);
    logic [4:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             start;
    logic [WIDTH-1:0] alu_result;
    logic             zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output alu_control, src_a, src_b, start, input alu_result, zero, busy, done, hi, lo);
    modport slave (input alu_control, src_a, src_b, start, output alu_result, zero, busy, done, hi, lo);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: single-cycle ALU plus iterative mult/div into HI/LO.
// Define MULDIV_EARLY_OUT_EN to let MULT/MULTU finish once the multiplier runs out of set bits.
module alu_muldiv #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    alu_muldiv_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;
    logic [4:0] op;
    logic [WIDTH-1:0] a, b, res, hi_q, lo_q;
    logic [SHW-1:0] cnt;
    logic [2*WIDTH-1:0] mcand, acc, acc_next, prod;
    logic [WIDTH-1:0] mplier, quo, rem, dvsr, opa, quo_next, rem_next, q_fix, r_fix, mag_a, mag_b;
    logic [WIDTH:0] shl;
    logic sgn, accept, last, ge, is_div, neg_p, neg_r, done_q;
    assign op = bus.alu_control;
    assign a = bus.src_a;
    assign b = bus.src_b;
    always_comb begin
        res = '0;
        case (op)
            5'd0: res = a & b;
            5'd1: res = a | b;
            5'd2: res = a + b;
            5'd3: res = a ^ b;
            5'd4: res = b << a[SHW-1:0];
            5'd5: res = b >> a[SHW-1:0];
            5'd6: res = a - b;
            5'd7: res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            5'd8: res = $signed(b) >>> a[SHW-1:0];
            5'd9: res = {{(WIDTH-1){1'b0}}, a < b};
            5'd14: res = hi_q;
            5'd15: res = lo_q;
            default: res = '0;
        endcase
    end
    assign bus.alu_result = res;
    assign bus.zero = res == '0;
    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
    assign bus.done = done_q;
    // Both units work on magnitudes; signs are reapplied when the result is committed.
    always_comb begin
        sgn = ~op[0];
        accept = bus.start && state == IDLE && op >= 5'd10 && op <= 5'd13;
        mag_a = (sgn && a[WIDTH-1]) ? -a : a;
        mag_b = (sgn && b[WIDTH-1]) ? -b : b;
        acc_next = mplier[0] ? acc + mcand : acc;
        shl = {rem, quo[WIDTH-1]};
        ge = shl >= {1'b0, dvsr};
        rem_next = ge ? WIDTH'(shl - {1'b0, dvsr}) : shl[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
        prod = neg_p ? -acc_next : acc_next;
        q_fix = dvsr == '0 ? '1 : neg_p ? -quo_next : quo_next;
        r_fix = dvsr == '0 ? opa : neg_r ? -rem_next : rem_next;
        last = cnt == '0;
`ifdef MULDIV_EARLY_OUT_EN
        last = last || (!is_div && mplier[WIDTH-1:1] == '0);
`endif
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_next;
    always_comb begin
        state_next = state;
        bus.busy = state == RUN;
        if (state == IDLE && accept) state_next = RUN;
        else if (state == RUN && last) state_next = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {cnt, mcand, acc, mplier, quo, rem, dvsr, opa} <= '0;
            {is_div, neg_p, neg_r, done_q} <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                cnt <= SHW'(WIDTH - 1);
                mcand <= {{WIDTH{1'b0}}, mag_b};
                acc <= '0;
                mplier <= mag_a;
                quo <= mag_a;
                rem <= '0;
                dvsr <= mag_b;
                opa <= a;
                is_div <= op[2];
                neg_p <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r <= sgn & a[WIDTH-1];
            end else if (state == RUN) begin
                cnt <= cnt - 1'b1;
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                acc <= acc_next;
                quo <= quo_next;
                rem <= rem_next;
                if (last) begin
                    done_q <= 1'b1;
                    hi_q <= is_div ? r_fix : prod[2*WIDTH-1:WIDTH];
                    lo_q <= is_div ? q_fix : prod[WIDTH-1:0];
                end
            end else if (bus.start && op == 5'd16) hi_q <= a;
            else if (bus.start && op == 5'd17) lo_q <= a;
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed checks of ALU ops, mult/div results and timing, HI/LO moves and reset abort
module tb_alu_muldiv;
    typedef struct {logic [31:0] r; logic z;} aexp_t;
    typedef struct {logic [31:0] hi; logic [31:0] lo; int lat;} mexp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int errors = 0;
    aexp_t alu_q[$];
    mexp_t md_q[$];
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_M3 = 2;
`else
    localparam int LAT_M3 = 32;
`endif
    alu_muldiv_if #(.WIDTH(32)) bus();
    alu_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic ez);
        aexp_t e;
        alu_q.push_back('{er, ez});
        @(negedge clk);
        bus.alu_control = op;
        bus.src_a = a;
        bus.src_b = b;
        #1;
        e = alu_q.pop_front();
        chk({tag, ".res"}, bus.alu_result, e.r);
        chk({tag, ".zero"}, 32'(bus.zero), 32'(e.z));
    endtask

    task automatic run_md(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input int lat, input int inj);
        int n;
        mexp_t e;
        md_q.push_back('{ehi, elo, lat});
        @(negedge clk);
        bus.alu_control = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.alu_control = 5'd2;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            if (n == inj) begin
                bus.start = 1'b1;
                bus.alu_control = 5'd13;
            end else bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        e = md_q.pop_front();
        chk({tag, ".lat"}, 32'(n), 32'(e.lat));
        chk({tag, ".done"}, 32'(bus.done), 32'd1);
        chk({tag, ".hi"}, bus.hi, e.hi);
        chk({tag, ".lo"}, bus.lo, e.lo);
        @(negedge clk);
        chk({tag, ".done_off"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        bus.alu_control = 5'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        bus.start = 1'b0;
        #12;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.hi", bus.hi, 32'd0);
        chk("rst.lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        alu("add_wrap", 5'd2, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0);
        alu("sub_zero", 5'd6, 32'd5, 32'd5, 32'h0, 1'b1);
        alu("slt_neg", 5'd7, 32'h8000_0000, 32'h1, 32'h1, 1'b0);
        alu("sltu", 5'd9, 32'h8000_0000, 32'h1, 32'h0, 1'b1);
        alu("sra", 5'd8, 32'd4, 32'hF000_0000, 32'hFF00_0000, 1'b0);
        alu("srl", 5'd5, 32'd4, 32'hF000_0000, 32'h0F00_0000, 1'b0);
        alu("sll_wrapamt", 5'd4, 32'd33, 32'h1, 32'h2, 1'b0);
        alu("and", 5'd0, 32'hF0F0_1234, 32'hFF00_FF00, 32'hF000_1200, 1'b0);
        alu("or", 5'd1, 32'hF0F0_0000, 32'h0F00_000F, 32'hFFF0_000F, 1'b0);
        alu("xor", 5'd3, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0);
        alu("op20", 5'd20, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1);
        alu("mult_res0", 5'd10, 32'h5, 32'h7, 32'h0, 1'b1);
        run_md("mult", 5'd10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, LAT_M3, 0);
        alu("mflo", 5'd15, 32'h0, 32'h0, 32'hFFFF_FFEB, 1'b0);
        alu("mfhi", 5'd14, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0);
        run_md("div", 5'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32, 0);
        run_md("divu_z", 5'd13, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 32, 0);
        run_md("div_ovf", 5'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32, 0);
        run_md("multu_inj", 5'd11, 32'd3, 32'd5, 32'h0, 32'd15, LAT_M3, 10);
        run_md("multu_big", 5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32, 0);
        @(negedge clk);
        bus.alu_control = 5'd12;
        bus.src_a = 32'd100;
        bus.src_b = 32'd7;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort.busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.done", 32'(bus.done), 32'd0);
        chk("abort.hi", bus.hi, 32'd0);
        chk("abort.lo", bus.lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.alu_control = 5'd16;
        bus.src_a = 32'h1234;
        bus.start = 1'b1;
        @(negedge clk);
        bus.alu_control = 5'd17;
        bus.src_a = 32'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        chk("mthi", bus.hi, 32'h1234);
        chk("mtlo", bus.lo, 32'h5678);
        chk("mt.done", 32'(bus.done), 32'd0);
        chk("mt.busy", 32'(bus.busy), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
